ram_pg_nrnw: RTL and testbench
==============================

Name: ram_pg_nrnw

Overview:
- Parametrised multi-port register-file RAM with NUM_RD asynchronous read ports and NUM_WR synchronous write ports.
- Has an explicit power-gate sequencer: OFF, a wake-up delay, and a row-by-row re-initialisation before the array accepts traffic.
- Successor to the fixed 2R1W power-gated RAM, used for lane-scalable structures (PRF banks, issue-queue payload, active list) whose lanes can be gated off.
- Consumers must qualify all traffic with ready_o.

Parameters:
- DEPTH, 64, number of rows.
- INDEX, 6, address width; DEPTH <= 2**INDEX.
- WIDTH, 32, row width in bits.
- NUM_RD, 2, read ports (>=1).
- NUM_WR, 1, write ports (>=1).
- RESET_VAL, RAM_RESET_ZERO, init mode: RAM_RESET_ZERO, RAM_RESET_SEQ or RAM_RESET_NONE.
- SEQ_START, 0, row i initialises to SEQ_START+i in SEQ mode, truncated to WIDTH.
- WAKE_CYCLES, 4, cycles spent in WAKE after pwrGate_i falls (>=1).

Ports:
- clk, input, 1, clock; all state updates on posedge.
- reset_n, input, 1, synchronous active-low reset.
- pwrGate_i, input, 1, 1 = lane power-gated; sampled on clk.
- addrRd_i, input, NUM_RD*INDEX, read address, port p at bits [p*INDEX +: INDEX].
- addrWr_i, input, NUM_WR*INDEX, write address per port.
- we_i, input, NUM_WR, write enable per port.
- data_i, input, NUM_WR*WIDTH, write data per port.
- data_o, output, NUM_RD*WIDTH, read data per port.
- ready_o, output, 1, array powered and initialised; high only in ON.
- initBusy_o, input-free status output, 1, high in WAKE or INIT.

Behaviour:
- States: OFF, WAKE, INIT, ON. Registers: state, wakeCnt (ceil log2 WAKE_CYCLES+1), initPtr (INDEX bits).
- Reset (reset_n=0 at edge):
  - pwrGate_i=1 -> OFF.
  - Otherwise INIT, or ON when RESET_VAL=NONE.
  - wakeCnt=0, initPtr=0. ready_o=0 and initBusy_o per the new state.
  - Reset has priority over every other event.
  - Reset mid-INIT or mid-WAKE restarts from initPtr=0; array contents are not otherwise touched.
- Any state, pwrGate_i=1 (not in reset) -> OFF next edge. Writes in that cycle are dropped.
- OFF: pwrGate_i=0 -> WAKE, wakeCnt=0.
- WAKE: wakeCnt increments each edge. The edge where wakeCnt==WAKE_CYCLES-1 moves to INIT with initPtr=0, or to ON if RESET_VAL=NONE.
- INIT: each edge writes row initPtr with its init value and increments initPtr. The edge writing row DEPTH-1 moves to ON.
  - INIT takes exactly DEPTH cycles.
  - ready_o rises after the DEPTH-th INIT edge.
  - External we_i is ignored.
- ON: for each port w with we_i[w]=1, ram[addrWr_i[w]] <= data_i[w].
  - Same-address collision: the highest-index port wins.
  - Addresses >= DEPTH are ignored for writes.
- Reads are combinational: data_o[p]=ram[addrRd_i[p]] when ready_o=1, no same-cycle write bypass (old data).
  - With ready_o=0 or address >= DEPTH, data_o[p]=0 (see optional feature).
- Reset values: ready_o=0, data_o=0 while not ready. initBusy_o=1 iff the state after reset is INIT.
- Array rows are not reset directly; only INIT writes them.

Optional Feature:
- RAM_PG_XPROP_EN
  - Defined: entering OFF sets every row to all-X. data_o is all-X whenever ready_o=0 or the address is out of range. RAM_RESET_NONE wake-up therefore leaves X rows visible. Simulation-only power-gate emulation.
  - Undefined: rows hold their value through OFF and gated reads return 0. Fully synthesizable.

Decomposition:
- Shared package ram_pg_pkg:
  - RAM_RESET_ZERO/SEQ/NONE constants.
  - pg_state_t enum {PG_OFF, PG_WAKE, PG_INIT, PG_ON}.
- Sub-module ram_pg_ctrl: FSM plus wakeCnt/initPtr.
  - Outputs state, initPtr, initWe, ready_o, initBusy_o.
  - The top level holds the array, write-port priority and read muxing.

Test Plan (DEPTH=8, INDEX=3, WIDTH=8, NUM_RD=2, NUM_WR=2, WAKE_CYCLES=3):
1. Reset, RESET_VAL=SEQ, SEQ_START=4, pwrGate_i=0, reset_n released -> ready_o rises after the 8th edge. Port0 addr 0 reads 0x04, port1 addr 7 reads 0x0B.
2. In ON, port0 writes addr 3=0xAA and port1 writes addr 3=0x55 in the same cycle -> addr 3 reads 0x55. The same-cycle read of addr 3 shows the old value.
3. In ON, pwrGate_i=1 for 2 cycles with we_i=2'b11 -> ready_o=0 the next cycle and writes are dropped. After release, initBusy_o=1 for 3+8 cycles, then ready_o=1 and rows hold SEQ values.
4. pwrGate_i re-asserted during INIT at initPtr=5 -> OFF next edge. On release, full WAKE+INIT restarts from row 0 (11 cycles to ready).
5. reset_n=0 for 1 cycle mid-INIT (initPtr=4), RESET_VAL=ZERO -> initPtr=0 and ready_o rises 8 edges later. All rows read 0.
6. Out-of-range address (DEPTH=6, write addr 7) -> no row changes. Read addr 7 returns 0, or X with RAM_PG_XPROP_EN.

Source files
------------

// File: rtl/ram_pg_pkg.sv
// Shared definitions for the power-gated multi-port register-file RAM:
// init-mode constants and the power-gate sequencer state type.
package ram_pg_pkg;

    localparam int RAM_RESET_ZERO = 0;
    localparam int RAM_RESET_SEQ  = 1;
    localparam int RAM_RESET_NONE = 2;

    typedef enum logic [1:0] {
        PG_OFF  = 2'd0,
        PG_WAKE = 2'd1,
        PG_INIT = 2'd2,
        PG_ON   = 2'd3
    } pg_state_t;

endpackage

// File: rtl/ram_pg_ctrl.sv
// Power-gate sequencer: OFF -> WAKE (WAKE_CYCLES) -> INIT (DEPTH rows) -> ON.
// Exposes its state so the array and external checkers can follow it.
module ram_pg_ctrl
    import ram_pg_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int INDEX       = 6,
    parameter int WAKE_CYCLES = 4,
    parameter int RESET_VAL   = RAM_RESET_ZERO
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pwrGate_i,
    output pg_state_t        o_state,
    output logic [INDEX-1:0] o_init_ptr,
    output logic             o_init_we,
    output logic             o_ready,
    output logic             o_init_busy
);

    localparam int WCW = $clog2(WAKE_CYCLES + 1);
    localparam logic [WCW-1:0]   WAKE_LAST = WCW'(WAKE_CYCLES - 1);
    localparam logic [INDEX-1:0] ROW_LAST  = INDEX'(DEPTH - 1);
    // Without an init pass the array is usable as soon as power is back.
    localparam pg_state_t POWERED_STATE = (RESET_VAL == RAM_RESET_NONE) ? PG_ON : PG_INIT;

    pg_state_t        r_state;
    pg_state_t        w_state_nxt;
    logic [WCW-1:0]   r_wake_cnt;
    logic [WCW-1:0]   w_wake_nxt;
    logic [INDEX-1:0] r_init_ptr;
    logic [INDEX-1:0] w_ptr_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= pwrGate_i ? PG_OFF : POWERED_STATE;
            r_wake_cnt <= '0;
            r_init_ptr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wake_cnt <= w_wake_nxt;
            r_init_ptr <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wake_nxt  = r_wake_cnt;
        w_ptr_nxt   = r_init_ptr;
        if (pwrGate_i) begin
            w_state_nxt = PG_OFF;
            w_wake_nxt  = '0;
            w_ptr_nxt   = '0;
        end else begin
            case (r_state)
                PG_OFF: begin
                    w_state_nxt = PG_WAKE;
                    w_wake_nxt  = '0;
                end
                PG_WAKE: begin
                    if (r_wake_cnt == WAKE_LAST) begin
                        w_state_nxt = POWERED_STATE;
                        w_wake_nxt  = '0;
                        w_ptr_nxt   = '0;
                    end else begin
                        w_wake_nxt = r_wake_cnt + 1'b1;
                    end
                end
                PG_INIT: begin
                    w_ptr_nxt = r_init_ptr + 1'b1;
                    if (r_init_ptr == ROW_LAST) begin
                        w_state_nxt = PG_ON;
                    end
                end
                default: w_state_nxt = PG_ON;
            endcase
        end
    end

    assign o_state     = r_state;
    assign o_init_ptr  = r_init_ptr;
    assign o_init_we   = (r_state == PG_INIT) && reset_n && !pwrGate_i;
    assign o_ready     = (r_state == PG_ON);
    assign o_init_busy = (r_state == PG_WAKE) || (r_state == PG_INIT);

endmodule

// File: rtl/ram_pg_nrnw.sv
// Power-gated NUM_RD-read / NUM_WR-write register-file RAM with async reads.
// Define RAM_PG_XPROP_EN for simulation-only X emulation of the gated array.
module ram_pg_nrnw
    import ram_pg_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int INDEX       = 6,
    parameter int WIDTH       = 32,
    parameter int NUM_RD      = 2,
    parameter int NUM_WR      = 1,
    parameter int RESET_VAL   = RAM_RESET_ZERO,
    parameter int SEQ_START   = 0,
    parameter int WAKE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    pwrGate_i,
    input  logic [NUM_RD*INDEX-1:0] addrRd_i,
    input  logic [NUM_WR*INDEX-1:0] addrWr_i,
    input  logic [NUM_WR-1:0]       we_i,
    input  logic [NUM_WR*WIDTH-1:0] data_i,
    output logic [NUM_RD*WIDTH-1:0] data_o,
    output logic                    ready_o,
    output logic                    initBusy_o
);

    localparam logic [INDEX:0] DEPTH_EXT = (INDEX+1)'(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    pg_state_t         w_state;
    logic [INDEX-1:0]  w_init_ptr;
    logic              w_init_we;
    logic              w_ready;
    logic              w_wr_en;
    logic [WIDTH-1:0]  w_init_val;
    logic [NUM_WR-1:0] w_wr_ok;

    ram_pg_ctrl #(
        .DEPTH       (DEPTH),
        .INDEX       (INDEX),
        .WAKE_CYCLES (WAKE_CYCLES),
        .RESET_VAL   (RESET_VAL)
    ) u_ctrl (
        .clk         (clk),
        .reset_n     (reset_n),
        .pwrGate_i   (pwrGate_i),
        .o_state     (w_state),
        .o_init_ptr  (w_init_ptr),
        .o_init_we   (w_init_we),
        .o_ready     (w_ready),
        .o_init_busy (initBusy_o)
    );

    assign ready_o    = w_ready;
    assign w_wr_en    = (w_state == PG_ON) && reset_n && !pwrGate_i;
    assign w_init_val = (RESET_VAL == RAM_RESET_SEQ) ? WIDTH'(SEQ_START + int'(w_init_ptr)) : '0;

    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr_ok
        assign w_wr_ok[w] = ({1'b0, addrWr_i[w*INDEX +: INDEX]} < DEPTH_EXT);
    end

    // Ports are visited in ascending order so the highest-index port wins a collision.
    always_ff @(posedge clk) begin
`ifdef RAM_PG_XPROP_EN
        if (pwrGate_i && (w_state != PG_OFF)) begin
            for (int r = 0; r < DEPTH; r++) begin
                r_mem[r] <= 'x;
            end
        end else
`endif
        if (w_init_we) begin
            r_mem[w_init_ptr] <= w_init_val;
        end else if (w_wr_en) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (we_i[w] && w_wr_ok[w]) begin
                    r_mem[addrWr_i[w*INDEX +: INDEX]] <= data_i[w*WIDTH +: WIDTH];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [INDEX-1:0] w_rd_addr;
        logic             w_rd_ok;
        assign w_rd_addr = addrRd_i[p*INDEX +: INDEX];
        assign w_rd_ok   = w_ready && ({1'b0, w_rd_addr} < DEPTH_EXT);
`ifdef RAM_PG_XPROP_EN
        assign data_o[p*WIDTH +: WIDTH] = w_rd_ok ? r_mem[w_rd_addr] : 'x;
`else
        assign data_o[p*WIDTH +: WIDTH] = w_rd_ok ? r_mem[w_rd_addr] : '0;
`endif
    end

endmodule

// File: tb/tb_ram_pg_nrnw.sv
// Bench for ram_pg_nrnw: three instances (SEQ depth 8, ZERO depth 8, ZERO depth 6)
// share one stimulus stream and are checked each cycle against a countdown model.
module tb_ram_pg_nrnw;
    import ram_pg_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, pwr_gate;
    logic [5:0]  addr_rd, addr_wr;
    logic [1:0]  we;
    logic [15:0] data_w;
    logic [15:0] dout_a, dout_b, dout_c;
    logic        rdy_a, rdy_b, rdy_c, busy_a, busy_b, busy_c;
    logic [15:0] dout [3];
    logic        rdy [3];
    logic        ibusy [3];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int n;
    logic [2:0] a3;
    logic [7:0] oor_exp;

    always #5 clk = ~clk;

    ram_pg_nrnw #(.DEPTH(8), .INDEX(3), .WIDTH(8), .NUM_RD(2), .NUM_WR(2),
                  .RESET_VAL(RAM_RESET_SEQ), .SEQ_START(4), .WAKE_CYCLES(3)) u_a (
        .clk(clk), .reset_n(reset_n), .pwrGate_i(pwr_gate), .addrRd_i(addr_rd),
        .addrWr_i(addr_wr), .we_i(we), .data_i(data_w), .data_o(dout_a),
        .ready_o(rdy_a), .initBusy_o(busy_a));

    ram_pg_nrnw #(.DEPTH(8), .INDEX(3), .WIDTH(8), .NUM_RD(2), .NUM_WR(2),
                  .RESET_VAL(RAM_RESET_ZERO), .SEQ_START(0), .WAKE_CYCLES(3)) u_b (
        .clk(clk), .reset_n(reset_n), .pwrGate_i(pwr_gate), .addrRd_i(addr_rd),
        .addrWr_i(addr_wr), .we_i(we), .data_i(data_w), .data_o(dout_b),
        .ready_o(rdy_b), .initBusy_o(busy_b));

    ram_pg_nrnw #(.DEPTH(6), .INDEX(3), .WIDTH(8), .NUM_RD(2), .NUM_WR(2),
                  .RESET_VAL(RAM_RESET_ZERO), .SEQ_START(0), .WAKE_CYCLES(3)) u_c (
        .clk(clk), .reset_n(reset_n), .pwrGate_i(pwr_gate), .addrRd_i(addr_rd),
        .addrWr_i(addr_wr), .we_i(we), .data_i(data_w), .data_o(dout_c),
        .ready_o(rdy_c), .initBusy_o(busy_c));

    assign dout[0]  = dout_a;
    assign dout[1]  = dout_b;
    assign dout[2]  = dout_c;
    assign rdy[0]   = rdy_a;
    assign rdy[1]   = rdy_b;
    assign rdy[2]   = rdy_c;
    assign ibusy[0] = busy_a;
    assign ibusy[1] = busy_b;
    assign ibusy[2] = busy_c;

    // Model: per instance, a powered-off flag, a count of cycles left before the
    // array is usable (wake first, then one row per cycle), and the row contents.
    int         dep   [3] = '{8, 8, 6};
    bit         seq_m [3] = '{1'b1, 1'b0, 1'b0};
    logic [7:0] m_mem [3][8];
    bit         m_ready [3];
    bit         m_off [3];
    int         m_busy [3];

    task automatic power_off(input int k);
`ifdef RAM_PG_XPROP_EN
        if (!m_off[k]) for (int r = 0; r < 8; r++) m_mem[k][r] = 'x;
`endif
        m_off[k]   = 1'b1;
        m_ready[k] = 1'b0;
        m_busy[k]  = 0;
    endtask

    task automatic model_step(input int k);
        int row;
        int a;
        if (!reset_n) begin
            if (pwr_gate) begin
                power_off(k);
            end else begin
                m_off[k]   = 1'b0;
                m_ready[k] = 1'b0;
                m_busy[k]  = dep[k];
            end
        end else if (pwr_gate) begin
            power_off(k);
        end else if (m_off[k]) begin
            m_off[k]  = 1'b0;
            m_busy[k] = 3 + dep[k];
        end else if (m_busy[k] > 0) begin
            if (m_busy[k] <= dep[k]) begin
                row = dep[k] - m_busy[k];
                m_mem[k][row] = seq_m[k] ? 8'(4 + row) : 8'h00;
            end
            m_busy[k]--;
            if (m_busy[k] == 0) m_ready[k] = 1'b1;
        end else if (m_ready[k]) begin
            for (int w = 0; w < 2; w++) begin
                a = int'(addr_wr[w*3 +: 3]);
                if (we[w] && a < dep[k]) m_mem[k][a] = data_w[w*8 +: 8];
            end
        end
    endtask

    function automatic logic [7:0] model_read(input int k, input int p);
        int a;
        a = int'(addr_rd[p*3 +: 3]);
        if (m_ready[k] && a < dep[k]) return m_mem[k][a];
        return oor_exp;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) model_step(k);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("model_ready[%0d]", k), 16'(rdy[k]), 16'(m_ready[k]));
                chk($sformatf("model_busy[%0d]", k), 16'(ibusy[k]), 16'(m_busy[k] > 0));
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("model_rd[%0d][%0d]", k, p), 16'(dout[k][p*8 +: 8]),
                        16'(model_read(k, p)));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef RAM_PG_XPROP_EN
        oor_exp = 'x;
`else
        oor_exp = 8'h00;
`endif
        reset_n = 1'b0; pwr_gate = 1'b1; we = 2'b00;
        addr_rd = '0; addr_wr = '0; data_w = '0;
        step(); step();
        chk_en = 1'b1;
        chk("rst_off_ready", 16'(rdy_a), 16'd0);
        chk("rst_off_busy", 16'(busy_a), 16'd0);
        pwr_gate = 1'b0;
        step();
        chk("rst_init_busy", 16'(busy_a), 16'd1);
        chk("rst_init_ready", 16'(rdy_a), 16'd0);

        // 1: init from reset, SEQ values
        reset_n = 1'b1;
        n = 0;
        while (!rdy_a && n < 40) begin step(); n++; end
        chk("t1_ready_edges", 16'(n), 16'd8);
        addr_rd = {3'd7, 3'd0};
        #1;
        chk("t1_p0_a0", 16'(dout_a[7:0]), 16'h04);
        chk("t1_p1_a7", 16'(dout_a[15:8]), 16'h0B);

        // 2: write collision, old data visible in the write cycle
        addr_wr = {3'd3, 3'd3}; data_w = {8'h55, 8'hAA}; we = 2'b11;
        addr_rd = {3'd3, 3'd3};
        #1;
        chk("t2_old_data", 16'(dout_a[7:0]), 16'h07);
        step();
        we = 2'b00;
        #1;
        chk("t2_port1_wins", 16'(dout_a[7:0]), 16'h55);

        // 3: gate in ON with writes pending, then full re-power
        pwr_gate = 1'b1; we = 2'b11; addr_wr = {3'd1, 3'd0}; data_w = 16'hEEDD;
        step();
        chk("t3_ready_drop", 16'(rdy_a), 16'd0);
        step();
        pwr_gate = 1'b0; we = 2'b00;
        step();
        n = 0;
        while (busy_a && n < 40) begin n++; step(); end
        chk("t3_busy_cycles", 16'(n), 16'd11);
        chk("t3_ready", 16'(rdy_a), 16'd1);
        addr_rd = {3'd1, 3'd0};
        #1;
        chk("t3_row0", 16'(dout_a[7:0]), 16'h04);
        chk("t3_row1", 16'(dout_a[15:8]), 16'h05);

        // 4: gate during INIT at row 5 restarts the whole sequence
        pwr_gate = 1'b1; step();
        pwr_gate = 1'b0; step();
        repeat (3) step();
        repeat (5) step();
        pwr_gate = 1'b1; step();
        chk("t4_off_ready", 16'(rdy_a), 16'd0);
        chk("t4_off_busy", 16'(busy_a), 16'd0);
        pwr_gate = 1'b0; step();
        n = 0;
        while (busy_a && n < 40) begin n++; step(); end
        chk("t4_busy_cycles", 16'(n), 16'd11);

        // 5: fill rows, then reset mid-INIT at row 4 of the ZERO instance
        for (int a = 0; a < 8; a++) begin
            we = 2'b01; addr_wr = {3'd0, 3'(a)}; data_w = 16'(8'h30 + a);
            step();
        end
        we = 2'b00;
        pwr_gate = 1'b1; step();
        pwr_gate = 1'b0; step();
        repeat (3) step();
        repeat (4) step();
        reset_n = 1'b0; step();
        chk("t5_rst_busy", 16'(busy_b), 16'd1);
        reset_n = 1'b1;
        n = 0;
        while (!rdy_b && n < 40) begin step(); n++; end
        chk("t5_ready_edges", 16'(n), 16'd8);
        for (int a = 0; a < 8; a++) begin
            a3 = 3'(a);
            addr_rd = {a3, a3};
            #1;
            chk("t5_zero_row", 16'(dout_b[7:0]), 16'h00);
            step();
        end

        // 6: out-of-range write/read on the depth-6 instance
        we = 2'b01; addr_wr = {3'd0, 3'd7}; data_w = 16'h0099;
        step();
        we = 2'b00; addr_rd = {3'd0, 3'd7};
        #1;
        chk("t6_c_oor_read", 16'(dout_c[7:0]), 16'(oor_exp));
        chk("t6_a_in_range", 16'(dout_a[7:0]), 16'h99);
        for (int a = 0; a < 6; a++) begin
            addr_rd = {3'(a), 3'd7};
            step();
        end
        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
